// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   PCSEL_*            next-PC source encodings driven on pc_sel
//   pipe_ctrl_state_t  controller FSM state type
package pipe_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;  // PC + 4
    localparam logic [1:0] PCSEL_BR  = 2'd1;  // branch / jump target
    localparam logic [1:0] PCSEL_INT = 2'd2;  // interrupt vector
    localparam logic [1:0] PCSEL_EPC = 2'd3;  // return address held in EPC

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_INT_VEC  = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Ports:
//   ex_mem_read  in   EX instruction is a load
//   ex_rt        in   destination register of the EX load
//   id_rs        in   rs of the ID instruction
//   id_rt        in   rt of the ID instruction
//   id_uses_rt   in   ID instruction reads rt as a source
//   load_use     out  ID must wait one cycle for the load result
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    // $zero never carries a real dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC write enable, IF/ID and ID/EX flushes,
// next-PC select, interrupt entry, eret return and divider stalls.
// Build option: PIPE_CTRL_DIV_STALL_EN enables the multi-cycle divider stall
// (DIV_WAIT state and its counter); without it id_div_start is ignored and
// div_busy is tied low.
// Ports:
//   cpu_clk, reset_n                 clock (FSM on posedge), async active-low reset
//   id_rs, id_rt, id_uses_rt         ID-stage source operands
//   ex_mem_read, ex_rt               EX-stage load and its destination
//   ex_branch_taken                  branch/jump resolved taken in EX
//   id_div_start, id_eret            ID instruction is div/divu, eret
//   int_req                          masked level interrupt request
//   pc_write, ifid_flush, idex_flush pipeline register controls
//   pc_sel                           next-PC source (pipe_pkg PCSEL_*)
//   epc_save                         CP0 captures ID-stage PC this cycle
//   int_ack, back_from_eret          registered one-cycle pulses
//   div_busy                         divider stall in progress
//
// state       | meaning
// ------------+----------------------------------------------
// ST_RUN      | normal issue, hazard priority resolution
// ST_DIV_WAIT | divider in progress, front end frozen
// ST_INT_VEC  | redirect fetch to the interrupt vector
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       cpu_clk,
    input  logic       reset_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       id_div_start,
    input  logic       id_eret,
    input  logic       int_req,
    output logic       pc_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic [1:0] pc_sel,
    output logic       epc_save,
    output logic       int_ack,
    output logic       back_from_eret,
    output logic       div_busy
);

    pipe_ctrl_state_t state_q, state_d;
    logic             load_use;
    logic             eret_go;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

`ifdef PIPE_CTRL_DIV_STALL_EN
    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_go;

    // A div only issues when nothing of higher priority claims the cycle.
    assign div_go = id_div_start && !int_req && !ex_branch_taken &&
                    !id_eret && !load_use;
`else
    logic unused_div;
    assign unused_div = id_div_start ^ DIV_CYCLES[0];
`endif

    // State register plus the registered one-cycle pulses.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            int_ack        <= 1'b0;
            back_from_eret <= 1'b0;
`ifdef PIPE_CTRL_DIV_STALL_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            int_ack        <= (state_q == ST_INT_VEC);
            back_from_eret <= eret_go;
`ifdef PIPE_CTRL_DIV_STALL_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
`ifdef PIPE_CTRL_DIV_STALL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (int_req) begin
                    state_d = ST_INT_VEC;
                end
`ifdef PIPE_CTRL_DIV_STALL_EN
                else if (div_go) begin
                    // The issue cycle is the first stall cycle, so DIV_WAIT
                    // lasts one cycle less than the divider latency.
                    state_d = ST_DIV_WAIT;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
`endif
            end
`ifdef PIPE_CTRL_DIV_STALL_EN
            ST_DIV_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_INT_VEC: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic; reset overrides so the pipeline registers are held
    // cleared while reset_n is low.
    always_comb begin
        pc_write   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_sel     = PCSEL_SEQ;
        epc_save   = 1'b0;
        div_busy   = 1'b0;
        eret_go    = 1'b0;
        if (!reset_n) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (int_req) begin
                        epc_save   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        pc_write   = 1'b0;
                    end else if (ex_branch_taken) begin
                        pc_sel     = PCSEL_BR;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (id_eret) begin
                        pc_sel     = PCSEL_EPC;
                        ifid_flush = 1'b1;
                        eret_go    = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        idex_flush = 1'b1;
                    end
`ifdef PIPE_CTRL_DIV_STALL_EN
                    else if (id_div_start) begin
                        // div itself moves on to EX, only the front end holds.
                        pc_write   = 1'b0;
                    end
`endif
                end
`ifdef PIPE_CTRL_DIV_STALL_EN
                ST_DIV_WAIT: begin
                    pc_write   = 1'b0;
                    idex_flush = 1'b1;
                    div_busy   = 1'b1;
                end
`endif
                ST_INT_VEC: begin
                    pc_sel     = PCSEL_INT;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    pc_write   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. A cycle-level reference model
// (remaining stall cycles, pending vector, pending pulses) predicts every
// output; directed scenarios are followed by a randomized run.
module tb_pipe_hazard_ctrl;

    localparam int DIV_CYCLES = 32;
`ifdef PIPE_CTRL_DIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       cpu_clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken;
    logic       id_div_start, id_eret, int_req;
    logic       pc_write, ifid_flush, idex_flush, epc_save;
    logic       int_ack, back_from_eret, div_busy;
    logic [1:0] pc_sel;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .cpu_clk         (cpu_clk),
        .reset_n         (reset_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_div_start    (id_div_start),
        .id_eret         (id_eret),
        .int_req         (int_req),
        .pc_write        (pc_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pc_sel          (pc_sel),
        .epc_save        (epc_save),
        .int_ack         (int_ack),
        .back_from_eret  (back_from_eret),
        .div_busy        (div_busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int stall_left = 0;   // DIV_WAIT cycles still to come
    bit vec_next   = 0;   // next cycle redirects to the vector
    bit ack_now    = 0;   // int_ack expected this cycle
    bit bfe_now    = 0;   // back_from_eret expected this cycle

    bit         e_pw, e_iff, e_ixf, e_epc, e_busy, e_ack, e_bfe;
    logic [1:0] e_sel;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urt, input bit mr, input logic [4:0] ert,
                        input bit br, input bit div, input bit eret, input bit irq);
        bit lu, nxt_vec, nxt_ack, nxt_bfe;
        @(posedge cpu_clk);
        #1;
        reset_n         = rst;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_mem_read     = mr;
        ex_rt           = ert;
        ex_branch_taken = br;
        id_div_start    = div;
        id_eret         = eret;
        int_req         = irq;
        @(negedge cpu_clk);

        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        e_ack = ack_now;
        e_bfe = bfe_now;
        e_pw = 1; e_iff = 0; e_ixf = 0; e_sel = 2'd0; e_epc = 0; e_busy = 0;
        nxt_vec = 0; nxt_ack = 0; nxt_bfe = 0;
        if (!rst) begin
            e_pw = 0; e_iff = 1; e_ixf = 1; e_ack = 0; e_bfe = 0;
            stall_left = 0;
        end else if (vec_next) begin
            e_sel = 2'd2; e_iff = 1; e_ixf = 1;
            nxt_ack = 1;
        end else if (stall_left > 0) begin
            e_pw = 0; e_ixf = 1; e_busy = 1;
            stall_left--;
        end else if (irq) begin
            e_epc = 1; e_iff = 1; e_ixf = 1; e_pw = 0;
            nxt_vec = 1;
        end else if (br) begin
            e_sel = 2'd1; e_iff = 1; e_ixf = 1;
        end else if (eret) begin
            e_sel = 2'd3; e_iff = 1;
            nxt_bfe = 1;
        end else if (lu) begin
            e_pw = 0; e_ixf = 1;
        end else if (div && DIV_EN) begin
            e_pw = 0;
            stall_left = DIV_CYCLES - 1;
        end
        vec_next = nxt_vec;
        ack_now  = nxt_ack;
        bfe_now  = nxt_bfe;

        check_val("pc_write",       32'(pc_write),       32'(e_pw));
        check_val("ifid_flush",     32'(ifid_flush),     32'(e_iff));
        check_val("idex_flush",     32'(idex_flush),     32'(e_ixf));
        check_val("pc_sel",         32'(pc_sel),         32'(e_sel));
        check_val("epc_save",       32'(epc_save),       32'(e_epc));
        check_val("div_busy",       32'(div_busy),       32'(e_busy));
        check_val("int_ack",        32'(int_ack),        32'(e_ack));
        check_val("back_from_eret", 32'(back_from_eret), 32'(e_bfe));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int  low_cnt, busy_cnt;
    bit  epc_seen;

    initial begin
        reset_n = 0; id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_branch_taken = 0; id_div_start = 0;
        id_eret = 0; int_req = 0;

        // Reset state, then release.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use on rs, then on rt, then $zero (no stall), then rt unused.
        step(1, 5, 0, 0, 1, 5, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 7, 1, 1, 7, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 1, 7, 0, 0, 0, 0);

        // Taken branch overrides a load-use hazard.
        step(1, 5, 0, 0, 1, 5, 1, 0, 0, 0);
        idle(1);

        // eret alone, then eret together with an interrupt.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Divider stall with int_req raised at cycle 5 and held until taken.
        low_cnt = 0; busy_cnt = 0; epc_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, (i == 0), 0, (i >= 5) && !epc_seen);
            if (i < DIV_CYCLES) begin
                if (pc_write == 1'b0) low_cnt++;
                if (div_busy == 1'b1) busy_cnt++;
            end
            if (e_epc) epc_seen = 1;
        end
`ifdef PIPE_CTRL_DIV_STALL_EN
        check_val("div_stall_len", 32'(low_cnt), 32'(DIV_CYCLES));
        check_val("div_busy_len", 32'(busy_cnt), 32'(DIV_CYCLES - 1));
`endif
        check_val("int_taken", 32'(epc_seen), 32'd1);
        idle(2);

        // Reset in the middle of a divider stall.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DIV_CYCLES && stall_left > 10; i++) idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Reset in the vector cycle: no int_ack may follow.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
